chacha20_stream_loader: RTL and testbench

//  Upstream bus-master feeder for the chacha20_poly1305_opt register core. Latches key/nonce on start,

---
 rtl/chacha_bus_pkg.sv | 35 +++
 rtl/chacha_status_poller.sv | 96 +++++++++
 rtl/chacha20_stream_loader.sv | 197 +++++++++++++++++++
 tb/tb_chacha20_stream_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_bus_pkg.sv
// Register map, control codes and loader state encoding shared by the
// ChaCha20 stream loader and its status poller.
package chacha_bus_pkg;

  localparam logic [7:0] ADDR_CTRL       = 8'h08;
  localparam logic [7:0] ADDR_STATUS     = 8'h09;
  localparam logic [7:0] ADDR_KEY_BASE   = 8'h10;
  localparam logic [7:0] ADDR_NONCE_BASE = 8'h20;
  localparam logic [7:0] ADDR_BLOCK_BASE = 8'h30;

  localparam logic [31:0] CTRL_INIT = 32'd1;
  localparam logic [31:0] CTRL_NEXT = 32'd2;
  localparam logic [31:0] CTRL_DONE = 32'd4;

  typedef enum logic [3:0] {
    LD_IDLE,
    LD_KEY,
    LD_NONCE,
    LD_INIT,
    LD_WAIT,
    LD_DATA,
    LD_PAD,
    LD_NEXT,
    LD_FIN
  } ld_state_e;

  // One core bus access; registered as a whole onto the output pins.
  typedef struct packed {
    logic        cs;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } bus_req_t;

endpackage

// File: rtl/chacha_status_poller.sv
// Status poller: while active, requests a STATUS read, waits for it to
// complete on the bus, then idles POLL_GAP cycles before the next read.
// rd_req is a request for the cycle after; the top registers it onto cs.
// ready/timeout are valid in the cycle the read is on the bus and are
// consumed at the edge that ends that read.
// Optional: CHACHA_LOADER_POLL_TIMEOUT_EN enables the per-wait read limit.
module chacha_status_poller #(
  parameter int POLL_GAP      = 2,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  input  logic status_rdy,
  output logic rd_req,
  output logic ready,
  output logic timeout
);

  typedef enum logic [1:0] {PH_ISSUE, PH_INFLIGHT, PH_GAP} ph_e;

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  ph_e              ph, ph_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             miss;

  assign ready = active && (ph == PH_INFLIGHT) && status_rdy;
  assign miss  = active && (ph == PH_INFLIGHT) && !status_rdy;

`ifdef CHACHA_LOADER_POLL_TIMEOUT_EN
  localparam int PC_W = $clog2(TIMEOUT_POLLS + 1);
  logic [PC_W-1:0] poll_cnt;

  assign timeout = miss && (poll_cnt == PC_W'(TIMEOUT_POLLS - 1));

  // Count not-ready reads within the current wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    poll_cnt <= '0;
    else if (!active) poll_cnt <= '0;
    else if (miss)    poll_cnt <= poll_cnt + 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_POLLS > 0);
  assign timeout    = 1'b0;
`endif

  // Phase sequencing: issue -> read on bus -> gap -> read on bus ...
  always_comb begin
    ph_nxt  = ph;
    gap_nxt = gap_cnt;
    rd_req  = 1'b0;
    if (!active) begin
      ph_nxt = PH_ISSUE;
    end else begin
      case (ph)
        PH_ISSUE: begin
          rd_req = 1'b1;
          ph_nxt = PH_INFLIGHT;
        end
        PH_INFLIGHT: begin
          if (ready || timeout) begin
            ph_nxt = PH_ISSUE;
          end else if (POLL_GAP == 0) begin
            rd_req = 1'b1;             // back-to-back reads
          end else begin
            ph_nxt  = PH_GAP;
            gap_nxt = GAP_W'(POLL_GAP - 1);
          end
        end
        PH_GAP: begin
          if (gap_cnt == '0) begin
            rd_req = 1'b1;
            ph_nxt = PH_INFLIGHT;
          end else begin
            gap_nxt = gap_cnt - 1'b1;
          end
        end
        default: ph_nxt = PH_ISSUE;
      endcase
    end
  end

  // Phase and gap counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph      <= PH_ISSUE;
      gap_cnt <= '0;
    end else begin
      ph      <= ph_nxt;
      gap_cnt <= gap_nxt;
    end
  end

endmodule

// File: rtl/chacha20_stream_loader.sv
// ChaCha20 stream loader: latches key/nonce on start, programs the core,
// then turns a valid/ready word stream into 16-word block writes with a
// NEXT command per block (short last block zero-padded) and a final DONE.
// Every command is followed by a STATUS poll until the core reports ready.
// Optional: CHACHA_LOADER_POLL_TIMEOUT_EN enables the poll timeout and err.
module chacha20_stream_loader
  import chacha_bus_pkg::*;
#(
  parameter int POLL_GAP      = 2,
  parameter int TIMEOUT_POLLS = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [255:0]     key,
  input  logic [95:0]      nonce,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             cs,
  output logic             we,
  output logic [7:0]       address,
  output logic [31:0]      write_data,
  input  logic [31:0]      read_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] blocks_done
);

  ld_state_e        state, st_nxt, ret_st, ret_nxt;
  logic [3:0]       idx, idx_nxt;
  logic             last_q, last_nxt;
  logic [7:0][31:0] key_q;
  logic [2:0][31:0] nonce_q;
  bus_req_t         bus_q, req;
  logic             done_nxt, done_q;
  logic [CNT_W-1:0] blk_q, blk_nxt;
  logic             poll_rd, poll_rdy, poll_to;
  logic             accept;

  logic unused_rd;
  assign unused_rd = ^read_data[31:1];

  chacha_status_poller #(
    .POLL_GAP      (POLL_GAP),
    .TIMEOUT_POLLS (TIMEOUT_POLLS)
  ) u_poller (
    .clk        (clk),
    .reset_n    (reset_n),
    .active     (state == LD_WAIT),
    .status_rdy (read_data[0]),
    .rd_req     (poll_rd),
    .ready      (poll_rdy),
    .timeout    (poll_to)
  );

  assign accept      = (state == LD_IDLE) && start;
  assign s_ready     = (state == LD_DATA);
  assign busy        = (state != LD_IDLE);
  assign done        = done_q;
  assign blocks_done = blk_q;
  assign cs          = bus_q.cs;
  assign we          = bus_q.we;
  assign address     = bus_q.addr;
  assign write_data  = bus_q.data;

  // Next state and the bus access to present in the following cycle.
  always_comb begin
    st_nxt   = state;
    ret_nxt  = ret_st;
    idx_nxt  = idx;
    last_nxt = last_q;
    blk_nxt  = blk_q;
    done_nxt = 1'b0;
    req      = '0;
    case (state)
      LD_IDLE: begin
        if (start) begin
          st_nxt   = LD_KEY;
          idx_nxt  = '0;
          last_nxt = 1'b0;
          blk_nxt  = '0;
        end
      end
      LD_KEY: begin
        req     = '{cs: 1'b1, we: 1'b1, addr: ADDR_KEY_BASE + 8'(idx), data: key_q[idx[2:0]]};
        idx_nxt = idx + 1'b1;
        if (idx == 4'd7) begin
          st_nxt  = LD_NONCE;
          idx_nxt = '0;
        end
      end
      LD_NONCE: begin
        req     = '{cs: 1'b1, we: 1'b1, addr: ADDR_NONCE_BASE + 8'(idx), data: nonce_q[idx[1:0]]};
        idx_nxt = idx + 1'b1;
        if (idx == 4'd2) begin
          st_nxt  = LD_INIT;
          idx_nxt = '0;
        end
      end
      LD_INIT: begin
        req     = '{cs: 1'b1, we: 1'b1, addr: ADDR_CTRL, data: CTRL_INIT};
        ret_nxt = LD_DATA;
        st_nxt  = LD_WAIT;
      end
      LD_WAIT: begin
        if (poll_rd) req = '{cs: 1'b1, we: 1'b0, addr: ADDR_STATUS, data: 32'd0};
        if (poll_rdy) begin
          st_nxt   = ret_st;
          done_nxt = (ret_st == LD_IDLE);
        end else if (poll_to) begin
          st_nxt = LD_IDLE;            // abandon: no FIN, no done
        end
      end
      LD_DATA: begin
        if (s_valid) begin
          req     = '{cs: 1'b1, we: 1'b1, addr: ADDR_BLOCK_BASE + 8'(idx), data: s_data};
          idx_nxt = idx + 1'b1;
          if (idx == 4'd15) begin
            last_nxt = s_last;
            st_nxt   = LD_NEXT;
          end else if (s_last) begin
            last_nxt = 1'b1;
            st_nxt   = LD_PAD;
          end
        end
      end
      LD_PAD: begin
        req     = '{cs: 1'b1, we: 1'b1, addr: ADDR_BLOCK_BASE + 8'(idx), data: 32'd0};
        idx_nxt = idx + 1'b1;
        if (idx == 4'd15) st_nxt = LD_NEXT;
      end
      LD_NEXT: begin
        req     = '{cs: 1'b1, we: 1'b1, addr: ADDR_CTRL, data: CTRL_NEXT};
        blk_nxt = blk_q + 1'b1;
        ret_nxt = last_q ? LD_FIN : LD_DATA;
        idx_nxt = '0;
        st_nxt  = LD_WAIT;
      end
      LD_FIN: begin
        req     = '{cs: 1'b1, we: 1'b1, addr: ADDR_CTRL, data: CTRL_DONE};
        ret_nxt = LD_IDLE;
        st_nxt  = LD_WAIT;
      end
      default: st_nxt = LD_IDLE;
    endcase
  end

  // Control state, registered bus outputs and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= LD_IDLE;
      ret_st <= LD_IDLE;
      idx    <= '0;
      last_q <= 1'b0;
      bus_q  <= '0;
      done_q <= 1'b0;
      blk_q  <= '0;
    end else begin
      state  <= st_nxt;
      ret_st <= ret_nxt;
      idx    <= idx_nxt;
      last_q <= last_nxt;
      bus_q  <= req;
      done_q <= done_nxt;
      blk_q  <= blk_nxt;
    end
  end

  // Key/nonce snapshot taken only on an accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q   <= '0;
      nonce_q <= '0;
    end else if (accept) begin
      key_q   <= key;
      nonce_q <= nonce;
    end
  end

`ifdef CHACHA_LOADER_POLL_TIMEOUT_EN
  logic err_q;
  // Sticky timeout flag, cleared by the next accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          err_q <= 1'b0;
    else if (accept)                       err_q <= 1'b0;
    else if (state == LD_WAIT && poll_to)  err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_chacha20_stream_loader.sv
// Directed bench for chacha20_stream_loader: bus log + STATUS model,
// expected write sequences built from the key/nonce/message vectors.
module tb_chacha20_stream_loader;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic         s_valid, s_ready, s_last;
  logic [31:0]  s_data;
  logic         cs, we;
  logic [7:0]   address;
  logic [31:0]  write_data, read_data;
  logic         busy, done, err;
  logic [15:0]  blocks_done;

  chacha20_stream_loader #(.POLL_GAP(2), .TIMEOUT_POLLS(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key), .nonce(nonce),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cs(cs), .we(we), .address(address), .write_data(write_data),
    .read_data(read_data), .busy(busy), .done(done), .err(err),
    .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; bit we; logic [7:0] addr; logic [31:0] data; } acc_t;
  typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;

  acc_t         log_q[$];
  wr_t          exp_q[$];
  logic [31:0]  wq[$];
  logic [255:0] key1, key2;
  logic [95:0]  nonce1;
  int           n_chk = 0, n_pass = 0;
  int           cyc_n = 0, done_cnt = 0, rd_n = 0, rdy_after = 3;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bus log and core STATUS model: ready once rdy_after reads follow a CTRL write.
  initial begin
    read_data = '0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (done) done_cnt++;
      if (cs) log_q.push_back('{cyc_n, we, address, write_data});
      if (cs && we && address == 8'h08) rd_n = 0;
      if (cs && !we && address == 8'h09) begin
        rd_n++;
        read_data = (rd_n >= rdy_after) ? 32'd1 : 32'd0;
      end else begin
        read_data = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input int a, input logic [31:0] d);
    exp_q.push_back('{8'(a), d});
  endtask

  task automatic build_exp(input int n);
    int nb;
    exp_q.delete();
    for (int i = 0; i < 8; i++) push(8'h10 + i, key1[32*i +: 32]);
    for (int i = 0; i < 3; i++) push(8'h20 + i, nonce1[32*i +: 32]);
    push(8'h08, 32'd1);
    nb = (n + 15) / 16;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 16; j++) push(8'h30 + j, (b*16 + j < n) ? wq[b*16 + j] : 32'd0);
      push(8'h08, 32'd2);
    end
    push(8'h08, 32'd4);
  endtask

  task automatic check_writes(input string tag, input int base);
    int k = 0;
    for (int i = base; i < log_q.size(); i++) begin
      if (log_q[i].we) begin
        if (k < exp_q.size())
          chk($sformatf("%s_wr%0d", tag, k), 64'({log_q[i].addr, log_q[i].data}),
              64'({exp_q[k].addr, exp_q[k].data}));
        k++;
      end
    end
    chk({tag, "_nwrites"}, 64'(k), 64'(exp_q.size()));
  endtask

  task automatic do_start(input logic [255:0] k, input logic [95:0] n);
    @(negedge clk);
    key = k; nonce = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit use_last, input bit toggle, input string tag);
    int i = 0;
    int c = 0;
    bit ph = 1'b1;
    while (i < n && c < 3000) begin
      @(negedge clk);
      s_valid = toggle ? ph : 1'b1;
      ph      = ~ph;
      s_data  = wq[i];
      s_last  = use_last && (i == n - 1);
      #1;
      if (s_valid && s_ready) i++;
      c++;
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    chk({tag, "_fed"}, 64'(i), 64'(n));
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int base, d0, j, nrd;
    key1   = {32'hfeedface, 32'hdeadbeef, 32'h89abcdef, 32'h01234567,
              32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233};
    key2   = ~key1;
    nonce1 = {32'h03030303, 32'h02020202, 32'h01010101};
    start = 0; key = '0; nonce = '0; s_valid = 0; s_data = '0; s_last = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 64'(cs), 0);
    chk("rst_we", 64'(we), 0);
    chk("rst_addr", 64'(address), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_blocks", 64'(blocks_done), 0);
    chk("rst_sready", 64'(s_ready), 0);
    reset_n = 1'b1;

    // Full 16-word block with s_last on the last word.
    base = log_q.size(); d0 = done_cnt;
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(32'haaaaaaaa + i);
    do_start(key1, nonce1);
    feed(16, 1'b1, 1'b0, "t1");
    wait_idle("t1");
    build_exp(16);
    check_writes("t1", base);
    chk("t1_blocks", 64'(blocks_done), 1);
    chk("t1_done_cnt", 64'(done_cnt - d0), 1);
    j = -1;
    for (int i = base; i < log_q.size(); i++)
      if (j < 0 && log_q[i].we && log_q[i].addr == 8'h08 && log_q[i].data == 32'd1) j = i;
    chk("t1_init_found", 64'(j >= 0), 1);
    if (j >= 0 && j + 3 < log_q.size()) begin
      chk("t1_rd_after_init", 64'({log_q[j+1].we, log_q[j+1].addr}), 64'({1'b0, 8'h09}));
      chk("t1_rd_latency", 64'(log_q[j+1].cyc - log_q[j].cyc), 1);
      chk("t1_poll_gap", 64'(log_q[j+2].cyc - log_q[j+1].cyc), 3);
      nrd = 0;
      for (int i = j + 1; i < log_q.size() && !log_q[i].we; i++) nrd++;
      chk("t1_nreads", 64'(nrd), 3);
    end

    // Two-word message: zero-padded block.
    base = log_q.size(); d0 = done_cnt;
    wq.delete();
    wq.push_back(32'haaaaaaaa);
    wq.push_back(32'hbbbbbbbb);
    do_start(key1, nonce1);
    feed(2, 1'b1, 1'b0, "t2");
    wait_idle("t2");
    build_exp(2);
    check_writes("t2", base);
    chk("t2_blocks", 64'(blocks_done), 1);
    chk("t2_done_cnt", 64'(done_cnt - d0), 1);

    // 40 words, s_valid every other cycle, with a start pulse while busy.
    base = log_q.size(); d0 = done_cnt;
    wq.delete();
    for (int i = 0; i < 40; i++) wq.push_back(32'h5000_0000 + 32'h0101 * i);
    do_start(key1, nonce1);
    @(negedge clk);
    key = key2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_busy_held", 64'(busy), 1);
    feed(40, 1'b1, 1'b1, "t3");
    wait_idle("t3");
    build_exp(40);
    check_writes("t3", base);
    chk("t3_blocks", 64'(blocks_done), 3);
    chk("t3_done_cnt", 64'(done_cnt - d0), 1);

`ifdef CHACHA_LOADER_POLL_TIMEOUT_EN
    // Core never ready: timeout after the 4th read, no FIN, no done.
    base = log_q.size(); d0 = done_cnt;
    rdy_after = 1000000;
    do_start(key1, nonce1);
    wait_idle("t4");
    chk("t4_err", 64'(err), 1);
    chk("t4_done_cnt", 64'(done_cnt - d0), 0);
    nrd = 0; j = -1;
    for (int i = base; i < log_q.size(); i++) begin
      if (!log_q[i].we) nrd++;
      else j = i;
    end
    chk("t4_nreads", 64'(nrd), 4);
    if (j >= 0) chk("t4_last_write", 64'({log_q[j].addr, log_q[j].data}), 64'({8'h08, 32'd1}));
    rdy_after = 3;
    do_start(key1, nonce1);
    chk("t4_err_clear", 64'(err), 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
`endif

    // Reset in the middle of the second block.
    rdy_after = 3;
    wq.delete();
    for (int i = 0; i < 20; i++) wq.push_back(32'hc0de0000 + i);
    do_start(key1, nonce1);
    feed(20, 1'b0, 1'b0, "t5");
    chk("t5_cs_live", 64'(cs), 1);
    chk("t5_addr_live", 64'(address), 64'h33);
    chk("t5_blocks_live", 64'(blocks_done), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_cs_async", 64'(cs), 0);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_blocks", 64'(blocks_done), 0);
    chk("t5_sready", 64'(s_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_idle_cs", 64'(cs), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
